// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - requester and memory-port signal bundle for mem_port_arbiter
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req_i;
    logic [ADDR_W-1:0] if_addr_i;
    logic [DATA_W-1:0] if_rdata_o;
    logic              if_ready_o;
    logic              dm_req_i;
    logic              dm_we_i;
    logic [ADDR_W-1:0] dm_addr_i;
    logic [DATA_W-1:0] dm_wdata_i;
    logic [DATA_W-1:0] dm_rdata_o;
    logic              dm_ready_o;
    logic              mem_en_o;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic [DATA_W-1:0] mem_rdata_i;
    logic              stall_o;

    // Arbiter side
    modport slave (
        input  if_req_i, if_addr_i, dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i, mem_rdata_i,
        output if_rdata_o, if_ready_o, dm_rdata_o, dm_ready_o,
               mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o, stall_o
    );

    // Requesters and memory side
    modport master (
        output if_req_i, if_addr_i, dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i, mem_rdata_i,
        input  if_rdata_o, if_ready_o, dm_rdata_o, dm_ready_o,
               mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o, stall_o
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fixed-priority IF/DM sequencer for a single-ported fixed-latency memory
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 3
) (
    input  logic           clk_i,
    input  logic           rst_i,
    mem_port_arbiter_if.slave bus
);
    localparam logic [3:0] LAT = 4'(MEM_LAT);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t     state;
    logic [3:0] cnt;
    logic       owner_dm;
    logic       we_q;

    // Pipeline freeze: a requester is stalled until its own ready pulse
    assign bus.stall_o = rst_i & ((bus.if_req_i & ~bus.if_ready_o) |
                                  (bus.dm_req_i & ~bus.dm_ready_o));

    // Grant, issue, latency count and response capture
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state           <= IDLE;
            cnt             <= '0;
            owner_dm        <= 1'b0;
            we_q            <= 1'b0;
            bus.mem_en_o    <= 1'b0;
            bus.mem_we_o    <= 1'b0;
            bus.mem_addr_o  <= '0;
            bus.mem_wdata_o <= '0;
            bus.if_rdata_o  <= '0;
            bus.dm_rdata_o  <= '0;
            bus.if_ready_o  <= 1'b0;
            bus.dm_ready_o  <= 1'b0;
        end else begin
            bus.if_ready_o <= 1'b0;
            bus.dm_ready_o <= 1'b0;
            case (state)
                IDLE: begin
                    // DM wins a tie; IF is always a read
                    if (bus.dm_req_i) begin
                        owner_dm        <= 1'b1;
                        we_q            <= bus.dm_we_i;
                        bus.mem_en_o    <= 1'b1;
                        bus.mem_we_o    <= bus.dm_we_i;
                        bus.mem_addr_o  <= ADDR_W'(bus.dm_addr_i);
                        bus.mem_wdata_o <= DATA_W'(bus.dm_wdata_i);
                        state           <= ISSUE;
                    end else if (bus.if_req_i) begin
                        owner_dm        <= 1'b0;
                        we_q            <= 1'b0;
                        bus.mem_en_o    <= 1'b1;
                        bus.mem_we_o    <= 1'b0;
                        bus.mem_addr_o  <= ADDR_W'(bus.if_addr_i);
                        state           <= ISSUE;
                    end
                end
                ISSUE: begin
                    bus.mem_en_o <= 1'b0;
                    bus.mem_we_o <= 1'b0;
                    cnt          <= 4'd1;
                    state        <= WAIT;
                end
                WAIT: begin
                    if (cnt == LAT) begin
                        // Response is valid this cycle; writes leave rdata untouched
                        if (!we_q) begin
                            if (owner_dm) bus.dm_rdata_o <= DATA_W'(bus.mem_rdata_i);
                            else          bus.if_rdata_o <= DATA_W'(bus.mem_rdata_i);
                        end
                        bus.dm_ready_o <= owner_dm;
                        bus.if_ready_o <= ~owner_dm;
                        state          <= DONE;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                DONE: begin
                    // Requesters still show req here, so no grant on this edge
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Sequences a single-ported, fixed-latency unified memory shared by two requesters: instruction fetch (IF) and the data-memory stage (DM).
- Grants one request at a time, issues it to the memory port, counts the memory latency, captures the read data and returns a one-cycle ready pulse.
- Drives a global stall that freezes PC and all pipeline registers while any request is outstanding.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
MEM_LAT, 3, cycles from the issue cycle to the cycle in which mem_rdata_i is valid; legal range 1..15

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  reset, asynchronous, active-low
if_req_i  in  1  fetch request, level; held until if_ready_o seen
if_addr_i  in  ADDR_W  fetch address
if_rdata_o  out  DATA_W  fetched instruction, registered
if_ready_o  out  1  one-cycle pulse: if_rdata_o valid
dm_req_i  in  1  data request, level; held until dm_ready_o seen
dm_we_i  in  1  1 = write, 0 = read
dm_addr_i  in  ADDR_W  data address
dm_wdata_i  in  DATA_W  write data
dm_rdata_o  out  DATA_W  read data, registered
dm_ready_o  out  1  one-cycle pulse: access complete
mem_en_o  out  1  memory access strobe, one cycle per access
mem_we_o  out  1  memory write enable, valid with mem_en_o
mem_addr_o  out  ADDR_W  memory address
mem_wdata_o  out  DATA_W  memory write data
mem_rdata_i  in  DATA_W  memory read data
stall_o  out  1  pipeline freeze

Behaviour:
- Reset (rst_i = 0, any time, including mid-access):
  - FSM goes to IDLE, latency counter and grant owner are cleared, and every output goes to 0.
  - Any in-flight memory response is discarded; no ready pulse is produced.
- FSM states: IDLE, ISSUE, WAIT, DONE. All outputs except stall_o are registered.
- IDLE:
  - At a rising edge, if dm_req_i = 1, grant DM; else if if_req_i = 1, grant IF. Then go to ISSUE.
  - On grant, latch the owner, address, we and wdata. IF accesses are always reads.
  - With no request, remain in IDLE.
- ISSUE: lasts one cycle.
  - mem_en_o = 1, mem_we_o = latched we, mem_addr_o and mem_wdata_o = latched values.
  - Counter loads 1. Next state is WAIT.
- WAIT:
  - mem_en_o = 0 and mem_we_o = 0; address and data outputs hold.
  - Counter increments each cycle.
  - In the cycle where counter = MEM_LAT, data is valid: capture mem_rdata_i into the owner's rdata register (reads only; writes leave rdata unchanged). Then go to DONE.
  - For MEM_LAT = 1, data capture occurs in the first WAIT cycle.
- DONE: lasts one cycle.
  - The owner's ready_o = 1.
  - No grant is made at the edge leaving DONE, because requesters still show req at that edge. Next state is IDLE.
- Latency:
  - Request sampled at edge E0: issue cycle begins at E0, ready pulse occupies the cycle starting at E(MEM_LAT+1).
  - Minimum spacing between consecutive issues is MEM_LAT+3 cycles.
- rdata_o holds its last captured value until the next completed read by the same owner.
- Priority:
  - DM has fixed priority over IF; a simultaneous request grants DM first.
  - The IF request waits and is granted at the first IDLE after DM completes, provided DM does not re-request. DM issues at most one access per instruction, so IF cannot starve.
- stall_o is combinational: (if_req_i & ~if_ready_o) | (dm_req_i & ~dm_ready_o). It is 0 during reset.
- A request deasserted before ready is a protocol violation.
  - If deasserted while the arbiter is in ISSUE/WAIT/DONE, the access still completes and the ready pulse is still produced.
  - No ready pulse is generated for a requester that was never granted.

Test Plan:
1. Reset, then IF read with if_req_i=1, if_addr_i=0x00000010, and the memory model returning 0x8C220004 at MEM_LAT=3:
   - mem_en_o high for exactly 1 cycle with mem_addr_o=0x10 and mem_we_o=0.
   - if_ready_o pulses 4 cycles after issue with if_rdata_o=0x8C220004.
   - stall_o stays high until the ready cycle.
2. Simultaneous if_req_i and dm_req_i (DM write, addr 0x100, wdata 0xDEADBEEF):
   - DM issues first with mem_we_o=1 and mem_wdata_o=0xDEADBEEF; dm_ready_o pulses.
   - IF issues 2 cycles after dm_ready_o; if_rdata_o is unaffected by the write.
3. DM read of 0x100 after test 2 → dm_rdata_o=0xDEADBEEF, and if_rdata_o keeps its prior value.
4. Assert rst_i=0 during WAIT of an IF read:
   - All outputs go to 0 asynchronously; no if_ready_o pulse follows.
   - After release, a fresh IF request completes normally.
5. Sweep MEM_LAT ∈ {1, 2, 15} with back-to-back IF requests → issue-to-ready = MEM_LAT+1 cycles; issue spacing = MEM_LAT+3 cycles.
6. Hold if_req_i across the DONE cycle → no second mem_en_o at the DONE→IDLE edge; exactly one access per request.
